// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the core_ctrl command controller.
// Holds the opcode enum, the FSM state enum, the channel-depth codes, the image
// size and the display-origin limit, plus small opcode classification helpers.
package core_pkg;

    localparam int unsigned IMG_BYTES = 2048;
    localparam int unsigned ORG_MAX   = 6;

    typedef enum logic [3:0] {
        OpLoad      = 4'd0,
        OpRight     = 4'd1,
        OpLeft      = 4'd2,
        OpUp        = 4'd3,
        OpDown      = 4'd4,
        OpDepthDown = 4'd5,
        OpDepthUp   = 4'd6,
        OpDisplay   = 4'd7,
        OpConv      = 4'd8,
        OpMedian    = 4'd9,
        OpSobelNms  = 4'd10
    } op_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWaitOp  = 3'd1,
        StLoad    = 3'd2,
        StExec    = 3'd3,
        StWaitEng = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        Depth8  = 2'd0,
        Depth16 = 2'd1,
        Depth32 = 2'd2
    } depth_e;

    // Opcodes 7..10 hand off to an external engine.
    function automatic logic is_eng_op(input logic [3:0] mode);
        return (mode >= 4'(OpDisplay)) && (mode <= 4'(OpSobelNms));
    endfunction

    // Opcodes 11..15 are undefined and run as one-cycle no-ops.
    function automatic logic is_illegal_op(input logic [3:0] mode);
        return mode > 4'(OpSobelNms);
    endfunction

    function automatic logic [1:0] eng_sel_of(input logic [3:0] mode);
        logic [3:0] diff;
        diff = mode - 4'(OpDisplay);
        return diff[1:0];
    endfunction

endpackage

// File: rtl/core_ctrl.sv
// core_ctrl: opcode-driven controller for an image core.
// Requests an op (o_op_ready pulse), then either streams a 2048-byte image load
// into SRAM, nudges the display origin / channel depth, or launches an engine
// and waits for its done pulse.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_op_valid, i_op_mode   opcode handshake input
//   o_op_ready              one-cycle request for the next op
//   i_in_valid, o_in_ready  load byte handshake
//   o_ld_we, o_ld_addr      SRAM write strobe and address for load bytes
//   o_org_row, o_org_col    display origin, each 0..6
//   o_depth                 channel depth code (0=8, 1=16, 2=32)
//   o_eng_start, o_eng_sel  engine launch pulse and engine select
//   i_eng_done              engine completion pulse
//   o_err                   sticky illegal-opcode flag, present only when
//                           CORE_CTRL_ILLEGAL_ERR_EN is defined
module core_ctrl
    import core_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_op_valid,
    input  logic [3:0]  i_op_mode,
    output logic        o_op_ready,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_ld_we,
    output logic [10:0] o_ld_addr,
    output logic [2:0]  o_org_row,
    output logic [2:0]  o_org_col,
    output logic [1:0]  o_depth,
    output logic        o_eng_start,
    output logic [1:0]  o_eng_sel,
    input  logic        i_eng_done
`ifdef CORE_CTRL_ILLEGAL_ERR_EN
    ,
    output logic        o_err
`endif
);

    state_e      state_q, state_d;
    logic [3:0]  mode_q;
    logic [10:0] cnt_q;
    logic [2:0]  row_q, col_q;
    logic [1:0]  depth_q;
    logic [1:0]  eng_sel_q;
    logic        op_accept;
    logic        last_byte;

    assign op_accept = (state_q == StWaitOp) && i_op_valid;
    assign last_byte = (cnt_q == 11'(IMG_BYTES - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StWaitOp;
            StWaitOp: begin
                if (i_op_valid) begin
                    if (i_op_mode == 4'(OpLoad)) begin
                        state_d = StLoad;
                    end else if (is_eng_op(i_op_mode)) begin
                        state_d = StWaitEng;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StLoad: begin
                if (i_in_valid && last_byte) begin
                    state_d = StIdle;
                end
            end
            StExec: state_d = StIdle;
            StWaitEng: begin
                if (i_eng_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic; op_ready is masked while reset holds the FSM in IDLE so the
    // pulse lands on the first cycle after release.
    always_comb begin
        o_op_ready  = (state_q == StIdle) && !i_rst;
        o_in_ready  = (state_q == StLoad);
        o_ld_we     = (state_q == StLoad) && i_in_valid;
        o_eng_start = op_accept && is_eng_op(i_op_mode);
    end

    // Load counter, latched op, origin/depth and engine-select registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q    <= 4'd0;
            cnt_q     <= 11'd0;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            depth_q   <= Depth32;
            eng_sel_q <= 2'd0;
        end else begin
            if (op_accept) begin
                mode_q <= i_op_mode;
                if (is_eng_op(i_op_mode)) begin
                    eng_sel_q <= eng_sel_of(i_op_mode);
                end
            end
            if (o_ld_we) begin
                cnt_q <= last_byte ? 11'd0 : cnt_q + 11'd1;
            end
            if (state_q == StExec) begin
                case (mode_q)
                    4'(OpRight): if (col_q != 3'(ORG_MAX)) col_q <= col_q + 3'd1;
                    4'(OpLeft):  if (col_q != 3'd0)        col_q <= col_q - 3'd1;
                    4'(OpDown):  if (row_q != 3'(ORG_MAX)) row_q <= row_q + 3'd1;
                    4'(OpUp):    if (row_q != 3'd0)        row_q <= row_q - 3'd1;
                    4'(OpDepthUp):   if (depth_q != Depth32) depth_q <= depth_q + 2'd1;
                    4'(OpDepthDown): if (depth_q != Depth8)  depth_q <= depth_q - 2'd1;
                    default: ;
                endcase
            end
        end
    end

`ifdef CORE_CTRL_ILLEGAL_ERR_EN
    logic err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (op_accept && is_illegal_op(i_op_mode)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`endif

    assign o_ld_addr = cnt_q;
    assign o_org_row = row_q;
    assign o_org_col = col_q;
    assign o_depth   = depth_q;
    assign o_eng_sel = eng_sel_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed self-checking bench for core_ctrl.
// Inputs change and outputs are sampled 1 time unit after the falling edge.
module tb_core_ctrl;
    import core_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_op_valid = 1'b0;
    logic [3:0]  i_op_mode = 4'd0;
    logic        o_op_ready;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic        o_ld_we;
    logic [10:0] o_ld_addr;
    logic [2:0]  o_org_row;
    logic [2:0]  o_org_col;
    logic [1:0]  o_depth;
    logic        o_eng_start;
    logic [1:0]  o_eng_sel;
    logic        i_eng_done = 1'b0;
`ifdef CORE_CTRL_ILLEGAL_ERR_EN
    logic        o_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    core_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_op_valid  (i_op_valid),
        .i_op_mode   (i_op_mode),
        .o_op_ready  (o_op_ready),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_ld_we     (o_ld_we),
        .o_ld_addr   (o_ld_addr),
        .o_org_row   (o_org_row),
        .o_org_col   (o_org_col),
        .o_depth     (o_depth),
        .o_eng_start (o_eng_start),
        .o_eng_sel   (o_eng_sel),
        .i_eng_done  (i_eng_done)
`ifdef CORE_CTRL_ILLEGAL_ERR_EN
        ,
        .o_err       (o_err)
`endif
    );

    task automatic tick;
        @(negedge i_clk);
        #1;
    endtask

    // Starts at an op_ready cycle; returns cycles from op accept to next op_ready.
    task automatic issue(input logic [3:0] mode, output int lat);
        tick;
        i_op_valid = 1'b1;
        i_op_mode  = mode;
        tick;
        i_op_valid = 1'b0;
        lat = 1;
        while (o_op_ready !== 1'b1 && lat < 100) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL rst_op_ready: got %b want 0", o_op_ready); end
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", o_in_ready); end
        checks++; if (o_ld_we !== 1'b0) begin errors++; $display("FAIL rst_ld_we: got %b want 0", o_ld_we); end
        checks++; if (o_ld_addr !== 11'd0) begin errors++; $display("FAIL rst_ld_addr: got %0d want 0", o_ld_addr); end
        checks++; if (o_org_row !== 3'd0 || o_org_col !== 3'd0) begin errors++; $display("FAIL rst_origin: got (%0d,%0d) want (0,0)", o_org_row, o_org_col); end
        checks++; if (o_depth !== 2'd2) begin errors++; $display("FAIL rst_depth: got %0d want 2", o_depth); end
        checks++; if (o_eng_start !== 1'b0 || o_eng_sel !== 2'd0) begin errors++; $display("FAIL rst_eng: got start=%b sel=%0d want 0/0", o_eng_start, o_eng_sel); end
`ifdef CORE_CTRL_ILLEGAL_ERR_EN
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", o_err); end
`endif
        i_rst = 1'b0;
        #1;
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL rel_op_ready: got %b want 1", o_op_ready); end
        checks++; if (o_depth !== 2'd2) begin errors++; $display("FAIL rel_depth: got %0d want 2", o_depth); end
    endtask

    task automatic test_load;
        int bad = 0;
        int strobes = 0;
        int exp_addr = 0;
        tick;
        i_op_valid = 1'b1;
        i_op_mode  = 4'd0;
        tick;
        i_op_valid = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) tick;
            i_in_valid = (i % 2 == 0);
            #1;
            if (o_ld_we) begin
                if (o_ld_addr !== 11'(exp_addr)) bad++;
                exp_addr++;
                strobes++;
            end
            if (o_ld_we !== (i % 2 == 0)) bad++;
            if (i < 4095 && o_in_ready !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL load_sequence: got %0d bad cycles want 0", bad); end
        checks++; if (strobes !== 2048) begin errors++; $display("FAIL load_strobes: got %0d want 2048", strobes); end
        checks++; if (o_op_ready !== 1'b1 || o_in_ready !== 1'b0) begin errors++; $display("FAIL load_exit: got op_ready=%b in_ready=%b want 1/0", o_op_ready, o_in_ready); end
        checks++; if (o_ld_addr !== 11'd0) begin errors++; $display("FAIL load_cnt_clear: got %0d want 0", o_ld_addr); end
        i_in_valid = 1'b0;
    endtask

    task automatic test_shift_right;
        int lat;
        int exp_col;
        for (int k = 0; k < 7; k++) begin
            issue(OpRight, lat);
            exp_col = (k + 1 > 6) ? 6 : k + 1;
            checks++; if (lat !== 2) begin errors++; $display("FAIL right_latency[%0d]: got %0d want 2", k, lat); end
            checks++; if (o_org_col !== 3'(exp_col)) begin errors++; $display("FAIL right_col[%0d]: got %0d want %0d", k, o_org_col, exp_col); end
        end
        checks++; if (o_org_row !== 3'd0) begin errors++; $display("FAIL right_row: got %0d want 0", o_org_row); end
    endtask

    task automatic test_moves;
        int lat;
        issue(OpDown, lat);
        issue(OpDown, lat);
        checks++; if (o_org_row !== 3'd2) begin errors++; $display("FAIL down_row: got %0d want 2", o_org_row); end
        issue(OpUp, lat);
        checks++; if (o_org_row !== 3'd1) begin errors++; $display("FAIL up_row: got %0d want 1", o_org_row); end
        issue(OpLeft, lat);
        checks++; if (o_org_col !== 3'd5) begin errors++; $display("FAIL left_col: got %0d want 5", o_org_col); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL left_latency: got %0d want 2", lat); end
    endtask

    task automatic test_depth;
        int lat;
        logic [1:0] exp_d [3] = '{2'd1, 2'd0, 2'd0};
        for (int k = 0; k < 3; k++) begin
            issue(OpDepthDown, lat);
            checks++; if (o_depth !== exp_d[k]) begin errors++; $display("FAIL depth_down[%0d]: got %0d want %0d", k, o_depth, exp_d[k]); end
        end
        issue(OpDepthUp, lat);
        checks++; if (o_depth !== 2'd1) begin errors++; $display("FAIL depth_up: got %0d want 1", o_depth); end
    endtask

    task automatic test_engine;
        int bad = 0;
        tick;
        i_op_valid = 1'b1;
        i_op_mode  = 4'd8;
        #1;
        checks++; if (o_eng_start !== 1'b1) begin errors++; $display("FAIL conv_start: got %b want 1", o_eng_start); end
        tick;
        i_op_valid = 1'b0;
        #1;
        checks++; if (o_eng_sel !== 2'd1) begin errors++; $display("FAIL conv_sel: got %0d want 1", o_eng_sel); end
        checks++; if (o_eng_start !== 1'b0) begin errors++; $display("FAIL conv_start_len: got %b want 0", o_eng_start); end
        for (int i = 0; i < 50; i++) begin
            if (o_op_ready !== 1'b0 || o_eng_start !== 1'b0 || o_eng_sel !== 2'd1) bad++;
            tick;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL conv_wait: got %0d bad cycles want 0", bad); end
        i_eng_done = 1'b1;
        #1;
        checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL conv_done_cycle: got %b want 0", o_op_ready); end
        tick;
        i_eng_done = 1'b0;
        #1;
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL conv_after_done: got %b want 1", o_op_ready); end
        // Sobel-NMS with an immediate done
        tick;
        i_op_valid = 1'b1;
        i_op_mode  = 4'd10;
        tick;
        i_op_valid = 1'b0;
        checks++; if (o_eng_sel !== 2'd3) begin errors++; $display("FAIL sobel_sel: got %0d want 3", o_eng_sel); end
        i_eng_done = 1'b1;
        tick;
        i_eng_done = 1'b0;
        #1;
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL sobel_done: got %b want 1", o_op_ready); end
    endtask

    task automatic test_illegal;
        int lat;
`ifdef CORE_CTRL_ILLEGAL_ERR_EN
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_before: got %b want 0", o_err); end
`endif
        issue(4'd12, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency: got %0d want 2", lat); end
        checks++; if (o_org_row !== 3'd1 || o_org_col !== 3'd5) begin errors++; $display("FAIL illegal_origin: got (%0d,%0d) want (1,5)", o_org_row, o_org_col); end
        checks++; if (o_depth !== 2'd1) begin errors++; $display("FAIL illegal_depth: got %0d want 1", o_depth); end
`ifdef CORE_CTRL_ILLEGAL_ERR_EN
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", o_err); end
`endif
    endtask

    task automatic test_reset_mid_op;
        tick;
        i_op_valid = 1'b1;
        i_op_mode  = 4'd0;
        tick;
        i_op_valid = 1'b0;
        i_in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) tick;
        checks++; if (o_ld_addr !== 11'd1000) begin errors++; $display("FAIL midload_addr: got %0d want 1000", o_ld_addr); end
        i_rst = 1'b1;
        #1;
        checks++; if (o_in_ready !== 1'b0 || o_ld_we !== 1'b0) begin errors++; $display("FAIL midload_abort: got in_ready=%b ld_we=%b want 0/0", o_in_ready, o_ld_we); end
        checks++; if (o_ld_addr !== 11'd0 || o_op_ready !== 1'b0) begin errors++; $display("FAIL midload_rst: got addr=%0d op_ready=%b want 0/0", o_ld_addr, o_op_ready); end
        checks++; if (o_org_col !== 3'd0 || o_depth !== 2'd2) begin errors++; $display("FAIL midload_regs: got col=%0d depth=%0d want 0/2", o_org_col, o_depth); end
`ifdef CORE_CTRL_ILLEGAL_ERR_EN
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", o_err); end
`endif
        i_in_valid = 1'b0;
        tick;
        i_rst = 1'b0;
        #1;
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL midload_rel: got %b want 1", o_op_ready); end
        tick;
        i_op_valid = 1'b1;
        i_op_mode  = 4'd0;
        tick;
        i_op_valid = 1'b0;
        i_in_valid = 1'b1;
        #1;
        checks++; if (o_ld_we !== 1'b1 || o_ld_addr !== 11'd0) begin errors++; $display("FAIL reload_first: got we=%b addr=%0d want 1/0", o_ld_we, o_ld_addr); end
        tick;
        checks++; if (o_ld_addr !== 11'd1) begin errors++; $display("FAIL reload_second: got %0d want 1", o_ld_addr); end
        i_in_valid = 1'b0;
        i_rst = 1'b1;
        tick;
        i_rst = 1'b0;
        #1;
        // Abort while waiting on the median engine
        tick;
        i_op_valid = 1'b1;
        i_op_mode  = 4'd9;
        tick;
        i_op_valid = 1'b0;
        checks++; if (o_eng_sel !== 2'd2) begin errors++; $display("FAIL median_sel: got %0d want 2", o_eng_sel); end
        i_rst = 1'b1;
        #1;
        checks++; if (o_eng_sel !== 2'd0 || o_op_ready !== 1'b0) begin errors++; $display("FAIL mideng_rst: got sel=%0d op_ready=%b want 0/0", o_eng_sel, o_op_ready); end
        tick;
        i_rst = 1'b0;
        #1;
        checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL mideng_rel: got %b want 1", o_op_ready); end
        tick;
        checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL op_ready_width: got %b want 0", o_op_ready); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_shift_right;
        test_moves;
        test_depth;
        test_engine;
        test_illegal;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck FSM cannot hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all flops rise-edge.
REQ-002 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port i_op_valid, input, 1 bit: op_mode is valid this cycle.
REQ-004 SHALL have port i_op_mode, input, 4 bits: opcode (0 load, 1 right, 2 left, 3 up, 4 down, 5 depth-down, 6 depth-up, 7 display, 8 conv, 9 median, 10 sobel-nms).
REQ-005 SHALL have port o_op_ready, output, 1 bit: one-cycle pulse requesting the next op.
REQ-006 SHALL have port i_in_valid, input, 1 bit: load byte valid.
REQ-007 SHALL have port o_in_ready, output, 1 bit: controller accepts load byte.
REQ-008 SHALL have port o_ld_we, output, 1 bit: SRAM write strobe for load byte.
REQ-009 SHALL have port o_ld_addr, output, 11 bits: load address 0..2047.
REQ-010 SHALL have ports o_org_row and o_org_col, output, 3 bits each: display origin.
REQ-011 SHALL have port o_depth, output, 2 bits: channel depth code (0=8, 1=16, 2=32).
REQ-012 SHALL have port o_eng_start, output, 1 bit: one-cycle engine start pulse.
REQ-013 SHALL have port o_eng_sel, output, 2 bits: engine select (0 display, 1 conv, 2 median, 3 sobel).
REQ-014 SHALL have port i_eng_done, input, 1 bit: engine finished (one-cycle pulse).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_OP, LOAD, EXEC, WAIT_ENG.
REQ-016 IDLE SHALL drive o_op_ready=1 for exactly one cycle, then go to WAIT_OP.
REQ-017 WAIT_OP SHALL hold until i_op_valid=1, then latch i_op_mode; mode 0 -> LOAD, 1..6 -> EXEC, 7..10 -> WAIT_ENG with o_eng_start=1 in the transition cycle.
REQ-018 i_op_valid outside WAIT_OP SHALL be ignored.
REQ-019 LOAD SHALL drive o_in_ready=1; each cycle with i_in_valid=1 SHALL assert o_ld_we combinationally, present the current counter on o_ld_addr, and increment the counter.
REQ-020 After the write at address 2047, LOAD SHALL drop o_in_ready in the next cycle, clear the counter to 0, and return to IDLE.
REQ-021 Cycles in LOAD with i_in_valid=0 SHALL leave the counter unchanged.
REQ-022 EXEC SHALL take one cycle: right/left SHALL change o_org_col by +1/-1, and down/up SHALL change o_org_row by +1/-1, each saturating in 0..6; then go to IDLE.
REQ-023 Depth-down and depth-up SHALL step o_depth within 0..2 and saturate at the ends.
REQ-024 WAIT_ENG SHALL hold until i_eng_done=1, then go to IDLE; o_eng_sel SHALL equal the latched mode minus 7 and SHALL be stable throughout.
REQ-025 An i_eng_done arriving outside WAIT_ENG SHALL be ignored.
REQ-026 Opcodes 11..15 SHALL be treated as no-ops: EXEC for one cycle with no state change, then IDLE.
REQ-027 Op-to-next-op_ready latency SHALL be 2 cycles for modes 1..6 (EXEC, then IDLE).

Reset
REQ-028 Asserting i_rst SHALL force state IDLE, o_op_ready=0, o_in_ready=0, o_ld_we=0, o_ld_addr=0, o_org_row=0, o_org_col=0, o_depth=2, o_eng_start=0, o_eng_sel=0, and clear the load counter.
REQ-029 Reset asserted mid-LOAD or mid-WAIT_ENG SHALL abort immediately; after release the first cycle SHALL be IDLE and SHALL pulse o_op_ready.

Configuration
REQ-030 With CORE_CTRL_ILLEGAL_ERR_EN defined, the block SHALL add port o_err (output, 1 bit), which is sticky-set on an opcode of 11..15 and cleared only by reset.
REQ-031 Without CORE_CTRL_ILLEGAL_ERR_EN, port o_err SHALL be absent and illegal opcodes SHALL behave only as in REQ-026.

Structure
REQ-032 A shared package core_pkg SHALL hold the opcode enum, the FSM state enum, the depth codes, and the constants IMG_BYTES=2048 and ORG_MAX=6.
REQ-033 The design SHALL have a single module with no sub-module; the origin/depth register update SHALL be in-line logic.

Verification
REQ-034 Reset release -> o_op_ready pulses on the first IDLE cycle; o_depth=2 and origin is (0,0).
REQ-035 Load with i_in_valid toggling 1/0 for 4096 cycles -> exactly 2048 o_ld_we strobes at addresses 0..2047 in order, then o_op_ready.
REQ-036 Seven right-shift ops -> o_org_col reaches 6 and stays there; each op_ready arrives 2 cycles after its op.
REQ-037 Three depth-down ops -> o_depth goes 1, 0, 0; then depth-up -> 1.
REQ-038 Mode 8 -> one o_eng_start with o_eng_sel=1; i_eng_done held off for 50 cycles -> no o_op_ready until 1 cycle after done.
REQ-039 Reset asserted at load byte 1000, then a new load -> addresses restart at 0; opcode 12 -> o_err=1 when the macro is defined and all state unchanged.
